// File: rtl/pad_share_arbiter.sv
// Round-robin owner arbitration for a single shared bidirectional pad, with a
// guaranteed tristate turnaround between owners and an optional hold timeout.
module pad_share_arbiter #(
    parameter int unsigned NumReq     = 4,
    parameter int unsigned TurnCycles = 2,
    parameter int unsigned MaxHold    = 16,
    parameter int unsigned IdxW       = $clog2(NumReq)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o,
    input  logic [NumReq-1:0] oe_i,
    input  logic [NumReq-1:0] out_i,
    output logic              in_o,
    output logic              pad_oen_o,
    output logic              pad_out_o,
    input  logic              pad_in_i,
    output logic [IdxW-1:0]   owner_o,
    output logic              busy_o
);

    localparam int unsigned HoldW = (MaxHold > 0) ? $clog2(MaxHold + 1) : 1;
    localparam int unsigned TurnW = $clog2(TurnCycles + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_e;

    state_e              state_q, state_d;
    logic [NumReq-1:0]   gnt_q, gnt_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [HoldW-1:0]    hold_q, hold_d;
    logic [TurnW-1:0]    turn_q, turn_d;

    logic [IdxW-1:0]     sel;
    logic                found;
    int unsigned         idx;
    logic                others_req;
    logic                hold_hit;
    logic                release_own;
    logic                launch;

    // Round-robin search: first set request at or above the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            if (!found && req_i[idx[IdxW-1:0]]) begin
                found = 1'b1;
                sel   = idx[IdxW-1:0];
            end
        end
    end

    always_comb begin
        others_req  = |(req_i & ~(NumReq'(1) << owner_q));
        hold_hit    = (MaxHold != 0) && (hold_q == HoldW'(MaxHold));
        release_own = ~req_i[owner_q] | (hold_hit & others_req);
    end

    // State register (plus the datapath registers that move with it).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
        end
    end

    // Next-state logic; a new grant can start from IDLE or from the last TURN cycle.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        launch  = 1'b0;

        case (state_q)
            IDLE: begin
                launch = found;
            end
            GRANT: begin
                if (release_own) begin
                    gnt_d   = '0;
                    turn_d  = TurnW'(TurnCycles);
                    state_d = TURN;
                end else if ((MaxHold != 0) && !hold_hit) begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            TURN: begin
                turn_d = turn_q - TurnW'(1);
                if (turn_q == TurnW'(1)) begin
                    turn_d  = '0;
                    launch  = found;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        if (launch) begin
            state_d = GRANT;
            gnt_d   = NumReq'(1) << sel;
            owner_d = sel;
            ptr_d   = (sel == IdxW'(NumReq - 1)) ? '0 : sel + IdxW'(1);
            hold_d  = HoldW'(1);
        end
    end

    // Outputs: only the registered owner may reach the pad, and only in GRANT.
    always_comb begin
        pad_oen_o = 1'b1;
        pad_out_o = 1'b0;
        if (state_q == GRANT) begin
            pad_oen_o = ~oe_i[owner_q];
            pad_out_o = out_i[owner_q] & oe_i[owner_q];
        end
        busy_o  = (state_q != IDLE);
        gnt_o   = gnt_q;
        owner_o = owner_q;
        in_o    = pad_in_i;
    end

endmodule

// File: tb/tb_pad_share_arbiter.sv
// Randomized scoreboard bench for pad_share_arbiter against a timeline-based
// reference model (grant edge, earliest next-arbitration edge, RR start).
module tb_pad_share_arbiter;

    localparam int N    = 4;
    localparam int TURN = 2;
    localparam int MAXH = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [N-1:0] oe;
    logic [N-1:0] dout;
    logic         in_o;
    logic         pad_oen;
    logic         pad_out;
    logic         pin;
    logic [1:0]   owner;
    logic         busy;

    pad_share_arbiter #(
        .NumReq    (N),
        .TurnCycles(TURN),
        .MaxHold   (MAXH)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .gnt_o    (gnt),
        .oe_i     (oe),
        .out_i    (dout),
        .in_o     (in_o),
        .pad_oen_o(pad_oen),
        .pad_out_o(pad_out),
        .pad_in_i (pin),
        .owner_o  (owner),
        .busy_o   (busy)
    );

    typedef struct {
        logic [N-1:0] gnt;
        logic [1:0]   owner;
        logic         busy;
        logic         oen;
        logic         pout;
        logic         pin;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: who holds the pad, when it was granted, and the first
    // edge at which a new arbitration is allowed after a release.
    int cyc;
    int m_owner;
    int m_last;
    int m_rr;
    int m_gedge;
    int m_free;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 0;
        m_rr    = 0;
        m_gedge = 0;
        m_free  = 0;
        cyc     = 0;
    endtask

    task automatic model_edge();
        logic others;
        if (m_owner >= 0) begin
            others = (req & ~(4'b0001 << m_owner)) != 0;
            if (!req[m_owner] || (MAXH != 0 && (cyc - m_gedge) >= MAXH && others)) begin
                m_owner = -1;
                m_free  = cyc + TURN;
            end
        end else if (cyc >= m_free) begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_rr + i) % N;
                if (req[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_rr    = (c + 1) % N;
                    m_gedge = cyc;
                    break;
                end
            end
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] oe_v,
                        input logic [N-1:0] out_v, input logic p);
        exp_t e;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        req  = r;
        oe   = oe_v;
        dout = out_v;
        pin  = p;
        e.gnt   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.owner = 2'(m_last);
        e.busy  = (m_owner >= 0) || (cyc < m_free);
        e.oen   = (m_owner >= 0) ? ~oe_v[m_owner] : 1'b1;
        e.pout  = (m_owner >= 0) ? (oe_v[m_owner] & out_v[m_owner]) : 1'b0;
        e.pin   = p;
        q.push_back(e);
    endtask

    // Toggle the pad input mid-cycle and confirm in_o follows without a clock.
    task automatic pin_probe();
        #1 pin = ~pin;
        #1 check("in_o_comb", in_o, pin);
        pin = ~pin;
        #1 check("in_o_comb_back", in_o, pin);
    endtask

    // Monitor: compares every registered expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("gnt", gnt, e.gnt);
                check("owner", owner, e.owner);
                check("busy", busy, e.busy);
                check("pad_oen", pad_oen, e.oen);
                check("pad_out", pad_out, e.pout);
                check("in_o", in_o, e.pin);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] r;
        rst_n = 1'b0;
        req   = '0;
        oe    = '0;
        dout  = '0;
        pin   = 1'b0;
        model_reset();

        @(negedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_oen", pad_oen, 1);
        check("rst_pout", pad_out, 0);
        check("rst_owner", owner, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Single requester, then handover to requester 3 through a turnaround.
        step(4'b0010, 4'b0010, 4'b0010, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0010, 4'b0010, 4'b0010, 1'(i));
        pin_probe();
        step(4'b1000, 4'b1010, 4'b1010, 1'b0);
        pin_probe();
        for (int i = 0; i < 4; i++) step(4'b1000, 4'b1000, 4'b1000, 1'b1);
        step(4'b1000, 4'b0000, 4'b1000, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Round robin: all request, each owner lets go in its grant cycle.
        for (int i = 0; i < 20; i++) begin
            r = 4'b1111;
            if (m_owner >= 0) r[m_owner] = 1'b0;
            step(r, 4'b1111, 4'(i), 1'(i));
        end

        // Hold timeout: two requesters that never let go.
        for (int i = 0; i < 24; i++) step(4'b0101, 4'b0101, 4'(i + 3), 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Random traffic.
        r = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (m_owner == i) begin
                    if ($urandom_range(5) == 0) r[i] = 1'b0;
                end else if (!r[i]) begin
                    r[i] = ($urandom_range(3) == 0);
                end else if ($urandom_range(15) == 0) begin
                    r[i] = 1'b0;
                end
            end
            step(r, 4'($urandom), 4'($urandom), 1'($urandom));
        end

        // Reset while owner 2 drives the pad.
        for (int i = 0; i < 8; i++) step(4'b0100, 4'b0100, 4'b0100, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gnt", gnt, 0);
        check("arst_oen", pad_oen, 1);
        check("arst_pout", pad_out, 0);
        check("arst_busy", busy, 0);
        check("arst_owner", owner, 0);
        pin_probe();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(4'b0100, 4'b0100, 4'b0100, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0000, 4'b0000, 4'b0000, 1'b0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
